// File: rtl/j1_irq_pkg.sv
// Shared definitions for the J1 interrupt controller: register offsets,
// CTRL bit positions, FSM state encoding and a priority helper.
package j1_irq_pkg;

    localparam logic [15:0] REG_PENDING = 16'h0000;
    localparam logic [15:0] REG_ENABLE  = 16'h0002;
    localparam logic [15:0] REG_CTRL    = 16'h0004;
    localparam logic [15:0] REG_CAUSE   = 16'h0006;
    localparam logic [15:0] REG_TIMER   = 16'h0008;

    localparam int CTRL_GIE  = 0;
    localparam int CTRL_BUSY = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        MASKED = 2'd2
    } irq_state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/j1_irq_sync.sv
// One interrupt source: SYNC_STAGES-deep synchroniser followed by a
// rising-edge detector (edge is valid the cycle after the last sync stage).
module j1_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetq,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/j1_irq_ctrl.sv
// IO-mapped interrupt controller for the J1 core. Optional reload timer
// source is built when J1_IRQ_TIMER_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for an enabled pending source with GIE set
//   ENTRY  | interrupt pulse to the core; GIE already cleared
//   MASKED | handler running; returns to IDLE once firmware sets GIE
module j1_irq_ctrl
    import j1_irq_pkg::*;
#(
    parameter int          NUM_SRC     = 8,
    parameter logic [15:0] IO_BASE     = 16'h0080,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               io_rd,
    input  logic               io_wr,
    input  logic [15:0]        io_addr,
    input  logic [15:0]        io_wdata,
    output logic [15:0]        io_rdata,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               irq_block,
    output logic               interrupt
);

`ifdef J1_IRQ_TIMER_EN
    localparam int NS = NUM_SRC + 1;
`else
    localparam int NS = NUM_SRC;
`endif
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NS) - 32'd1);

    irq_state_e   state, state_n;
    logic [15:0]  pending, enable, masked, edge_all, timer_bits;
    logic [NUM_SRC-1:0] src_edge;
    logic         gie, cause_valid, take, req;
    logic [3:0]   cause_idx;
    logic         wr_pend, wr_en, wr_ctrl, gie_clr_wr;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
        j1_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .resetq(resetq),
            .d     (irq_src[g]),
            .rise  (src_edge[g])
        );
    end

    assign wr_pend    = io_wr && (io_addr == IO_BASE + REG_PENDING);
    assign wr_en      = io_wr && (io_addr == IO_BASE + REG_ENABLE);
    assign wr_ctrl    = io_wr && (io_addr == IO_BASE + REG_CTRL);
    assign gie_clr_wr = wr_ctrl && !io_wdata[CTRL_GIE];

`ifdef J1_IRQ_TIMER_EN
    logic        wr_timer, tmr_tc;
    logic [15:0] tmr_reload, tmr_cnt;

    assign wr_timer = io_wr && (io_addr == IO_BASE + REG_TIMER);
    assign tmr_tc   = (tmr_cnt == 16'd1);

    // Down-counter; terminal count at 1 reloads. Writing 0 stops it.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tmr_reload <= 16'h0;
            tmr_cnt    <= 16'h0;
        end else if (wr_timer) begin
            tmr_reload <= io_wdata;
            tmr_cnt    <= io_wdata;
        end else if (tmr_tc) begin
            tmr_cnt <= tmr_reload;
        end else if (tmr_cnt != 16'h0) begin
            tmr_cnt <= tmr_cnt - 16'd1;
        end
    end

    // The terminal-count pulse is already one cycle wide, so it is an edge.
    assign timer_bits = 16'(tmr_tc) << NUM_SRC;
`else
    assign timer_bits = 16'h0;
`endif

    assign edge_all = 16'(src_edge) | timer_bits;
    assign masked   = pending & enable;
    assign req      = (|masked) & gie;

    always_comb begin
        state_n = state;
        take    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !irq_block && !gie_clr_wr) begin
                    take    = 1'b1;
                    state_n = ENTRY;
                end
            end
            ENTRY:   state_n = MASKED;
            MASKED:  if (gie) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state       <= IDLE;
            interrupt   <= 1'b0;
            pending     <= 16'h0;
            enable      <= 16'h0;
            gie         <= 1'b0;
            cause_valid <= 1'b0;
            cause_idx   <= 4'd0;
        end else begin
            state     <= state_n;
            interrupt <= take;
            // A new edge beats a simultaneous W1C on the same bit.
            pending   <= ((pending & ~(wr_pend ? io_wdata : 16'h0)) | edge_all) & SRC_MASK;
            if (wr_en) enable <= io_wdata & SRC_MASK;
            if (take) begin
                gie         <= 1'b0;
                cause_valid <= 1'b1;
                cause_idx   <= lowest_set(masked);
            end else if (wr_ctrl) begin
                gie <= io_wdata[CTRL_GIE];
            end
        end
    end

    always_comb begin
        io_rdata = 16'h0;
        if (io_rd) begin
            case (io_addr)
                IO_BASE + REG_PENDING: io_rdata = pending;
                IO_BASE + REG_ENABLE:  io_rdata = enable;
                IO_BASE + REG_CTRL:    io_rdata = {14'h0, state != IDLE, gie};
                IO_BASE + REG_CAUSE:   io_rdata = {11'h0, cause_valid, cause_idx};
`ifdef J1_IRQ_TIMER_EN
                IO_BASE + REG_TIMER:   io_rdata = tmr_reload;
`endif
                default:               io_rdata = 16'h0;
            endcase
        end
    end

endmodule

// File: doc/j1_irq_ctrl.md
Name: j1_irq_ctrl

Overview:
IO-mapped interrupt controller that drives the J1 core's single `interrupt` input from NUM_SRC external sources.
- Synchronises and edge-detects each source, latches it into a pending register and masks it with an enable register.
- Sequences interrupt entry: one-cycle `interrupt` pulse (core executes call 3FFE), then auto-clears global enable until firmware re-arms it.
- Sits beside the core on the io_rd/io_wr/mem_addr/dout bus; its read data is muxed into the core's io_din.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..15).
IO_BASE, 16'h0080, base IO address; registers at IO_BASE+0/2/4/6.
SYNC_STAGES, 2, synchroniser flops per source (>=2).

Ports:
clk  in  1  system clock.
resetq  in  1  asynchronous active-low reset.
io_rd  in  1  core IO read strobe.
io_wr  in  1  core IO write strobe.
io_addr  in  16  core mem_addr.
io_wdata  in  16  core dout (write data).
io_rdata  out  16  read data; combinational; 0 when io_addr is not decoded.
irq_src  in  NUM_SRC  asynchronous source lines; rising edge = request.
irq_block  in  1  top level asserts it while the core is in a memory-fetch cycle; no entry while high.
interrupt  out  1  registered entry pulse to the core.

Behaviour:
Clocking and reset:
- Single clock domain. All flops reset asynchronously on resetq low.
- Reset values: interrupt=0, PENDING=0, ENABLE=0, GIE=0, CAUSE=0, sync/edge flops=0, state=IDLE.

Register map (16-bit, unused bits read 0):
- +0 PENDING: R, W1C. Bit i is set on a synchronised rising edge of irq_src[i].
- +2 ENABLE: R/W, per-source mask.
- +4 CTRL: bit0 GIE R/W; bit1 BUSY (state!=IDLE), RO.
- +6 CAUSE: RO; {11'b0, valid, idx[3:0]} latched at entry.

Bus rules:
- Reads have no side effects; io_rd only qualifies them.
- A write takes effect at the clock edge where io_wr=1 and the address matches.

Edge detection:
- edge_i = sync_i & ~prev_i, with 1-cycle latency after the synchroniser.
- Edge and W1C clear on the same bit in the same cycle: set wins.

Request and priority:
- req = |(PENDING & ENABLE) & GIE.
- Lowest set index of PENDING & ENABLE wins.

FSM states: IDLE, ENTRY, MASKED.
- IDLE -> ENTRY when req & ~irq_block & ~(CTRL write with bit0=0 this cycle). The same edge latches CAUSE={valid=1, idx}, clears GIE and sets interrupt=1.
- ENTRY -> MASKED next cycle; interrupt=0. The pulse is exactly one cycle.
- MASKED -> IDLE on the edge after GIE becomes 1 (firmware eint). A CTRL write setting GIE=1 during ENTRY is honoured.
- The pending bit is not auto-cleared; the handler clears it via W1C.

Boundary cases:
- irq_block held high: entry is deferred indefinitely and PENDING keeps accumulating.
- resetq asserted during ENTRY: interrupt drops immediately (asynchronous).
- NUM_SRC<16: upper PENDING/ENABLE bits read 0, writes to them are ignored.

Optional Feature:
Macro J1_IRQ_TIMER_EN.
Defined:
- Adds a 16-bit down-counter timer as an extra source at index NUM_SRC (requires NUM_SRC<=14).
- Register +8 TIMER_RELOAD, R/W, reset 0. Writing a nonzero value loads the counter.
- Counter decrements each cycle. On reaching 1 it raises a one-cycle source pulse (fed straight to the edge stage, no synchroniser) and reloads.
- Reload=0 stops the timer.
Undefined:
- No timer logic; +8 decodes as unmapped (reads 0).

Decomposition:
- Package j1_irq_pkg: register offset constants (REG_PENDING=0, REG_ENABLE=2, REG_CTRL=4, REG_CAUSE=6, REG_TIMER=8), CTRL bit positions, FSM state enum (2-bit).
- Sub-module j1_irq_sync: per-source SYNC_STAGES synchroniser plus rising-edge detector, instantiated NUM_SRC times via generate.

Test Plan:
1. Reset then ENABLE=8'h04, GIE=1, pulse irq_src[2] -> PENDING=4 after SYNC_STAGES+1 cycles; interrupt high exactly 1 cycle on the next edge; CAUSE=16'h0012; GIE=0; BUSY=1.
2. Sources 5 and 1 rise in the same cycle, ENABLE=8'hFF, GIE=1 -> CAUSE idx=1. Handler W1C 16'h0002 then sets GIE=1 -> second entry pulse with CAUSE idx=5.
3. irq_block=1 for 10 cycles with a request pending -> interrupt stays 0. Drop irq_block -> pulse on the following edge.
4. Edge on src 3 coincident with W1C of bit 3 -> PENDING[3]=1 afterwards. Src 3 disabled (ENABLE[3]=0) -> no interrupt despite PENDING.
5. Pull resetq low while interrupt=1 -> interrupt=0 within the same cycle; all registers read 0 after release.
6. (J1_IRQ_TIMER_EN) TIMER_RELOAD=5, ENABLE bit NUM_SRC=1, GIE=1 -> first timer PENDING set 5 cycles after the write, then every 5 cycles. Write 0 -> no further sets.
